// File: rtl/axi_wr_sched.sv
// axi_wr_sched: AW-channel scheduler shared by M1 (CPU) and M2 (DMA).
//
// Arbitrates the two master AW channels round-robin, registers the winning
// address onto a single slave-side AW bus, and then locks the W-mux (WSEL)
// and B-demux (BSEL) to the granted master until its B response is taken.
// Only one write is outstanding at a time.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   AW*_M / AWVALID_M    packed {M2,M1} master-side address channels
//   AWREADY_M            {M2,M1} ready, combinational from AWREADY_S in ADDR
//   AW*_S / AWVALID_S    registered granted address toward the decoder
//   AWREADY_S            decoder accepted the address
//   W*_S, B*_S           slave-side W/B handshake, observed only
//   WSEL, BSEL           one-hot {M2,M1} routing selects
//   LEN_ERR              one-cycle pulse when WLAST disagrees with AWLEN
module axi_wr_sched #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*ID_BITS-1:0]   AWID_M,
  input  logic [2*ADDR_BITS-1:0] AWADDR_M,
  input  logic [2*LEN_BITS-1:0]  AWLEN_M,
  input  logic [2*SIZE_BITS-1:0] AWSIZE_M,
  input  logic [3:0]             AWBURST_M,
  input  logic [1:0]             AWVALID_M,
  output logic [1:0]             AWREADY_M,
  output logic [IDS_BITS-1:0]    AWID_S,
  output logic [ADDR_BITS-1:0]   AWADDR_S,
  output logic [LEN_BITS-1:0]    AWLEN_S,
  output logic [SIZE_BITS-1:0]   AWSIZE_S,
  output logic [1:0]             AWBURST_S,
  output logic                   AWVALID_S,
  input  logic                   AWREADY_S,
  input  logic                   WVALID_S,
  input  logic                   WREADY_S,
  input  logic                   WLAST_S,
  input  logic                   BVALID_S,
  input  logic                   BREADY_S,
  output logic [1:0]             WSEL,
  output logic [1:0]             BSEL,
  output logic                   LEN_ERR
);

  localparam int TAG_BITS = IDS_BITS - ID_BITS;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, WRESP} state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;   // 0 = M1, 1 = M2
  logic                 ptr_q, ptr_d;       // priority on tie: 0 = M1, 1 = M2
  logic [IDS_BITS-1:0]  awid_q, awid_d;
  logic [ADDR_BITS-1:0] awaddr_q, awaddr_d;
  logic [LEN_BITS-1:0]  awlen_q, awlen_d;
  logic [SIZE_BITS-1:0] awsize_q, awsize_d;
  logic [1:0]           awburst_q, awburst_d;
  logic                 awvalid_q, awvalid_d;
  logic [1:0]           wsel_q, wsel_d;
  logic [1:0]           bsel_q, bsel_d;
  logic                 len_err_q, len_err_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;

  logic                 win;
  logic [1:0]           owner_oh;
  logic                 w_hs;
  logic                 cnt_at_len;

  // M2 wins when it is the sole requester or when both request and the
  // pointer favours M2.
  assign win        = AWVALID_M[1] & (~AWVALID_M[0] | ptr_q);
  assign owner_oh   = owner_q ? 2'b10 : 2'b01;
  assign w_hs       = WVALID_S & WREADY_S;
  assign cnt_at_len = (cnt_q == awlen_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    awvalid_d = awvalid_q;
    wsel_d    = wsel_q;
    bsel_d    = bsel_q;
    len_err_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (|AWVALID_M) begin
          owner_d   = win;
          awid_d    = win ? {TAG_BITS'(2), AWID_M[2*ID_BITS-1:ID_BITS]}
                          : {TAG_BITS'(1), AWID_M[ID_BITS-1:0]};
          awaddr_d  = win ? AWADDR_M[2*ADDR_BITS-1:ADDR_BITS] : AWADDR_M[ADDR_BITS-1:0];
          awlen_d   = win ? AWLEN_M[2*LEN_BITS-1:LEN_BITS]    : AWLEN_M[LEN_BITS-1:0];
          awsize_d  = win ? AWSIZE_M[2*SIZE_BITS-1:SIZE_BITS] : AWSIZE_M[SIZE_BITS-1:0];
          awburst_d = win ? AWBURST_M[3:2]                    : AWBURST_M[1:0];
          awvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (awvalid_q && AWREADY_S) begin
          awvalid_d = 1'b0;
          cnt_d     = '0;
          ptr_d     = ~owner_q;
          wsel_d    = owner_oh;
          state_d   = WDATA;
        end
      end
      WDATA: begin
        if (w_hs) begin
          // Burst closes on whichever of WLAST or the beat count comes
          // first; the counter is not advanced on that beat so it cannot wrap.
          if (WLAST_S || cnt_at_len) begin
            len_err_d = WLAST_S ^ cnt_at_len;
            wsel_d    = '0;
            bsel_d    = owner_oh;
            state_d   = WRESP;
          end else begin
            cnt_d = cnt_q + LEN_BITS'(1);
          end
        end
      end
      WRESP: begin
        if (BVALID_S && BREADY_S) begin
          bsel_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      awvalid_q <= 1'b0;
      wsel_q    <= '0;
      bsel_q    <= '0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      awvalid_q <= awvalid_d;
      wsel_q    <= wsel_d;
      bsel_q    <= bsel_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign AWREADY_M = (state_q == ADDR && AWREADY_S) ? owner_oh : 2'b00;
  assign AWID_S    = awid_q;
  assign AWADDR_S  = awaddr_q;
  assign AWLEN_S   = awlen_q;
  assign AWSIZE_S  = awsize_q;
  assign AWBURST_S = awburst_q;
  assign AWVALID_S = awvalid_q;
  assign WSEL      = wsel_q;
  assign BSEL      = bsel_q;
  assign LEN_ERR   = len_err_q;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Scoreboard bench for axi_wr_sched: expected AW grants are queued when
// requests are driven and compared when the slave-side AW bus presents them.
module tb_axi_wr_sched;

  localparam int ID_BITS   = 4;
  localparam int IDS_BITS  = 8;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [ID_BITS-1:0]     id_m    [2];
  logic [ADDR_BITS-1:0]   addr_m  [2];
  logic [LEN_BITS-1:0]    len_m   [2];
  logic [SIZE_BITS-1:0]   size_m  [2];
  logic [1:0]             burst_m [2];
  logic [2*ID_BITS-1:0]   AWID_M;
  logic [2*ADDR_BITS-1:0] AWADDR_M;
  logic [2*LEN_BITS-1:0]  AWLEN_M;
  logic [2*SIZE_BITS-1:0] AWSIZE_M;
  logic [3:0]             AWBURST_M;
  logic [1:0]             AWVALID_M;
  logic [1:0]             AWREADY_M;
  logic [IDS_BITS-1:0]    AWID_S;
  logic [ADDR_BITS-1:0]   AWADDR_S;
  logic [LEN_BITS-1:0]    AWLEN_S;
  logic [SIZE_BITS-1:0]   AWSIZE_S;
  logic [1:0]             AWBURST_S;
  logic                   AWVALID_S;
  logic                   AWREADY_S;
  logic                   WVALID_S, WREADY_S, WLAST_S;
  logic                   BVALID_S, BREADY_S;
  logic [1:0]             WSEL, BSEL;
  logic                   LEN_ERR;

  assign AWID_M    = {id_m[1], id_m[0]};
  assign AWADDR_M  = {addr_m[1], addr_m[0]};
  assign AWLEN_M   = {len_m[1], len_m[0]};
  assign AWSIZE_M  = {size_m[1], size_m[0]};
  assign AWBURST_M = {burst_m[1], burst_m[0]};

  axi_wr_sched #(
    .ID_BITS(ID_BITS), .IDS_BITS(IDS_BITS), .ADDR_BITS(ADDR_BITS),
    .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
    .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M),
    .AWREADY_M(AWREADY_M),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S),
    .AWREADY_S(AWREADY_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S), .WLAST_S(WLAST_S),
    .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .WSEL(WSEL), .BSEL(BSEL), .LEN_ERR(LEN_ERR)
  );

  typedef struct {
    int          owner;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_t;

  aw_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    id_m[m] = id; addr_m[m] = addr; len_m[m] = len; size_m[m] = size; burst_m[m] = burst;
  endtask

  // Expected slave-side AW beat for master m, built from its current fields.
  task automatic expect_aw(input int m);
    aw_t e;
    e.owner = m;
    e.id    = {(m != 0) ? 4'd2 : 4'd1, id_m[m]};
    e.addr  = addr_m[m];
    e.len   = len_m[m];
    e.size  = size_m[m];
    e.burst = burst_m[m];
    sb.push_back(e);
  endtask

  // Entered just after a negedge; returns just after the negedge following
  // the AW handshake (DUT in WDATA).
  task automatic aw_phase(input int exp_lat, input int stall, input logic [1:0] drop,
                          output int owner, output int len);
    int  n;
    aw_t e;
    n = 0;
    owner = 0;
    len = 0;
    while (AWVALID_S !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (AWVALID_S !== 1'b1) begin
      check("aw_timeout", {63'd0, AWVALID_S}, 64'd1);
      return;
    end
    if (exp_lat >= 0) check("aw_latency", 64'(n), 64'(exp_lat));
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    owner = e.owner;
    len = int'(e.len);
    check("awid_s",    64'(AWID_S),    64'(e.id));
    check("awaddr_s",  64'(AWADDR_S),  64'(e.addr));
    check("awlen_s",   64'(AWLEN_S),   64'(e.len));
    check("awsize_s",  64'(AWSIZE_S),  64'(e.size));
    check("awburst_s", 64'(AWBURST_S), 64'(e.burst));
    check("awready_m_idle", 64'(AWREADY_M), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_awvalid", {63'd0, AWVALID_S}, 64'd1);
      check("stall_awaddr",  64'(AWADDR_S), 64'(e.addr));
      check("stall_awid",    64'(AWID_S),   64'(e.id));
      check("stall_awready_m", 64'(AWREADY_M), 64'd0);
      check("stall_wsel",    64'(WSEL), 64'd0);
    end
    AWREADY_S = 1'b1;
    #1;
    check("awready_m", 64'(AWREADY_M), 64'(onehot(owner)));
    @(posedge clk);
    #1;
    AWREADY_S = 1'b0;
    AWVALID_M = AWVALID_M & ~drop;
    @(negedge clk);
    check("awvalid_drop", {63'd0, AWVALID_S}, 64'd0);
    check("wsel_on", 64'(WSEL), 64'(onehot(owner)));
  endtask

  // last_beat = 0 means WLAST is never asserted.
  task automatic w_phase(input int owner, input int len, input int last_beat, input bit late_m2);
    int   exit_b;
    logic exp_err;
    exit_b  = (last_beat >= 1 && last_beat <= len + 1) ? last_beat : len + 1;
    exp_err = (last_beat != len + 1);
    for (int b = 1; b <= exit_b; b++) begin
      WVALID_S = 1'b1;
      WREADY_S = 1'b1;
      WLAST_S  = (b == last_beat);
      if (late_m2 && b == 1) AWVALID_M[1] = 1'b1;
      @(negedge clk);
      if (b < exit_b) begin
        check("wsel_mid",    64'(WSEL), 64'(onehot(owner)));
        check("bsel_mid",    64'(BSEL), 64'd0);
        check("len_err_mid", {63'd0, LEN_ERR}, 64'd0);
        check("awvalid_mid", {63'd0, AWVALID_S}, 64'd0);
      end else begin
        check("len_err_end", {63'd0, LEN_ERR}, {63'd0, exp_err});
        check("wsel_end",    64'(WSEL), 64'd0);
        check("bsel_end",    64'(BSEL), 64'(onehot(owner)));
      end
    end
    WVALID_S = 1'b0;
    WREADY_S = 1'b0;
    WLAST_S  = 1'b0;
    @(negedge clk);
    check("len_err_pulse", {63'd0, LEN_ERR}, 64'd0);
    check("awvalid_wresp", {63'd0, AWVALID_S}, 64'd0);
  endtask

  // Returns just after the negedge following the B handshake (DUT in IDLE).
  task automatic b_phase(input int owner, input int delay);
    for (int d = 0; d < delay; d++) begin
      check("bsel_wait",    64'(BSEL), 64'(onehot(owner)));
      check("wsel_wait",    64'(WSEL), 64'd0);
      check("awvalid_wait", {63'd0, AWVALID_S}, 64'd0);
      @(negedge clk);
    end
    BVALID_S = 1'b1;
    BREADY_S = 1'b1;
    @(negedge clk);
    BVALID_S = 1'b0;
    BREADY_S = 1'b0;
    check("bsel_clear", 64'(BSEL), 64'd0);
    check("wsel_clear", 64'(WSEL), 64'd0);
    check("awvalid_idle", {63'd0, AWVALID_S}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int owner, len;
    rst = 1'b0;
    AWVALID_M = 2'b00;
    AWREADY_S = 1'b0;
    WVALID_S = 1'b0; WREADY_S = 1'b0; WLAST_S = 1'b0;
    BVALID_S = 1'b0; BREADY_S = 1'b0;
    set_req(0, 4'h0, 32'h0, 4'h0, 3'h0, 2'h0);
    set_req(1, 4'h0, 32'h0, 4'h0, 3'h0, 2'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awvalid", {63'd0, AWVALID_S}, 64'd0);
    check("rst_awid",    64'(AWID_S), 64'd0);
    check("rst_awaddr",  64'(AWADDR_S), 64'd0);
    check("rst_awready", 64'(AWREADY_M), 64'd0);
    check("rst_wsel",    64'(WSEL), 64'd0);
    check("rst_bsel",    64'(BSEL), 64'd0);
    check("rst_len_err", {63'd0, LEN_ERR}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_awvalid", {63'd0, AWVALID_S}, 64'd0);

    // Simultaneous held requests: M1, M2, M1
    set_req(0, 4'h3, 32'h0000_1000, 4'h0, 3'h2, 2'h1);
    set_req(1, 4'hA, 32'h0000_2000, 4'h1, 3'h2, 2'h1);
    expect_aw(0); expect_aw(1); expect_aw(0);
    AWVALID_M = 2'b11;
    aw_phase(1, 0, 2'b00, owner, len);
    check("rr_owner1", 64'(owner), 64'd0);
    w_phase(owner, len, len + 1, 1'b0);
    b_phase(owner, 0);
    aw_phase(1, 0, 2'b00, owner, len);
    check("rr_owner2", 64'(owner), 64'd1);
    w_phase(owner, len, len + 1, 1'b0);
    b_phase(owner, 1);
    aw_phase(1, 0, 2'b11, owner, len);
    check("rr_owner3", 64'(owner), 64'd0);
    w_phase(owner, len, len + 1, 1'b0);
    b_phase(owner, 0);

    // Single M1 request: ADDR 0x0001_0000, LEN 3, ID 5 -> AWID_S 0x15
    set_req(0, 4'h5, 32'h0001_0000, 4'h3, 3'h2, 2'h1);
    expect_aw(0);
    AWVALID_M = 2'b01;
    aw_phase(1, 0, 2'b01, owner, len);
    w_phase(owner, len, 4, 1'b0);
    b_phase(owner, 2);

    // M2 alone with AWREADY_S held low 5 cycles
    set_req(1, 4'hC, 32'h8000_0040, 4'h2, 3'h3, 2'h2);
    expect_aw(1);
    AWVALID_M = 2'b10;
    aw_phase(1, 5, 2'b10, owner, len);
    w_phase(owner, len, 3, 1'b0);
    b_phase(owner, 0);

    // LEN=3, WLAST on beat 2
    set_req(0, 4'h7, 32'h0000_3000, 4'h3, 3'h2, 2'h1);
    expect_aw(0);
    AWVALID_M = 2'b01;
    aw_phase(1, 0, 2'b01, owner, len);
    w_phase(owner, len, 2, 1'b0);
    b_phase(owner, 0);

    // LEN=1, WLAST never asserted
    set_req(0, 4'h8, 32'h0000_4000, 4'h1, 3'h2, 2'h1);
    expect_aw(0);
    AWVALID_M = 2'b01;
    aw_phase(1, 0, 2'b01, owner, len);
    w_phase(owner, len, 0, 1'b0);
    b_phase(owner, 0);

    // M2 raises AWVALID during M1's burst; granted 1 cycle after IDLE
    set_req(0, 4'h9, 32'h0000_5000, 4'h1, 3'h2, 2'h1);
    set_req(1, 4'h4, 32'h0000_6000, 4'h0, 3'h1, 2'h0);
    expect_aw(0); expect_aw(1);
    AWVALID_M = 2'b01;
    aw_phase(1, 0, 2'b01, owner, len);
    w_phase(owner, len, 2, 1'b1);
    b_phase(owner, 3);
    aw_phase(1, 0, 2'b10, owner, len);
    check("late_owner", 64'(owner), 64'd1);
    w_phase(owner, len, 1, 1'b0);
    b_phase(owner, 0);

    // Reset mid-burst, then simultaneous request resolves to M1
    set_req(0, 4'h2, 32'h0000_7000, 4'h3, 3'h2, 2'h1);
    expect_aw(0);
    AWVALID_M = 2'b01;
    aw_phase(1, 0, 2'b01, owner, len);
    WVALID_S = 1'b1; WREADY_S = 1'b1; WLAST_S = 1'b0;
    @(negedge clk);
    WVALID_S = 1'b0; WREADY_S = 1'b0;
    check("pre_rst_wsel", 64'(WSEL), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_awvalid", {63'd0, AWVALID_S}, 64'd0);
    check("mid_rst_wsel",    64'(WSEL), 64'd0);
    check("mid_rst_bsel",    64'(BSEL), 64'd0);
    check("mid_rst_awaddr",  64'(AWADDR_S), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {63'd0, AWVALID_S}, 64'd0);
    set_req(0, 4'h1, 32'h0000_8000, 4'h0, 3'h2, 2'h1);
    set_req(1, 4'h6, 32'h0000_9000, 4'h1, 3'h2, 2'h1);
    expect_aw(0); expect_aw(1);
    AWVALID_M = 2'b11;
    aw_phase(1, 0, 2'b01, owner, len);
    check("post_rst_owner", 64'(owner), 64'd0);
    w_phase(owner, len, len + 1, 1'b0);
    b_phase(owner, 0);
    aw_phase(1, 0, 2'b10, owner, len);
    check("post_rst_m2", 64'(owner), 64'd1);
    w_phase(owner, len, len + 1, 1'b0);
    b_phase(owner, 0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
- Write-channel scheduler for the AXI interconnect, shared by master M1 (CPU) and master M2 (DMA).
- Arbitrates the AW channel between the two masters with round-robin priority.
- Registers the winning address onto a single slave-side AW bus, which the address decoder consumes.
- Holds the write path locked to the winner through its W burst and B response, so W and B routing always match the granted AW.

Parameters:
- ID_BITS, 4, master-side transaction ID width.
- IDS_BITS, 8, slave-side ID width (ID_BITS + 4-bit master tag).
- ADDR_BITS, 32, address width.
- LEN_BITS, 4, burst length width (beats = LEN+1).
- SIZE_BITS, 3, burst size width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- AWID_M  in  2*ID_BITS  packed {M2,M1} AW IDs.
- AWADDR_M  in  2*ADDR_BITS  packed {M2,M1} addresses.
- AWLEN_M  in  2*LEN_BITS  packed {M2,M1} lengths.
- AWSIZE_M  in  2*SIZE_BITS  packed {M2,M1} sizes.
- AWBURST_M  in  4  packed {M2,M1} burst types.
- AWVALID_M  in  2  {M2,M1} AW valid.
- AWREADY_M  out  2  {M2,M1} AW ready.
- AWID_S  out  IDS_BITS  {tag, AWID}; tag = 4'd1 for M1, 4'd2 for M2.
- AWADDR_S  out  ADDR_BITS  granted address.
- AWLEN_S  out  LEN_BITS  granted length.
- AWSIZE_S  out  SIZE_BITS  granted size.
- AWBURST_S  out  2  granted burst type.
- AWVALID_S  out  1  address valid toward decoder.
- AWREADY_S  in  1  decoder/slave accepted address.
- WVALID_S  in  1  W beat valid, slave side (observed only).
- WREADY_S  in  1  W beat ready, slave side (observed only).
- WLAST_S  in  1  W last flag, slave side (observed only).
- BVALID_S  in  1  B valid, slave side (observed only).
- BREADY_S  in  1  B ready, slave side (observed only).
- WSEL  out  2  one-hot {M2,M1} W-mux select.
- BSEL  out  2  one-hot {M2,M1} B-demux select.
- LEN_ERR  out  1  one-cycle pulse on burst length/WLAST mismatch.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; AWVALID_S=0; all AW*_S=0; AWREADY_M=0; WSEL=0; BSEL=0; LEN_ERR=0; beat counter=0; priority pointer on M1.
- FSM states: IDLE, ADDR, WDATA, WRESP.
- IDLE:
  - If any AWVALID_M bit is set, pick the winner: the single requester, or the pointer's master if both request.
  - Register the winner's fields onto AW*_S, set owner, go to ADDR.
  - AWVALID_S rises the cycle after the request is seen (1-cycle latency).
- ADDR:
  - AWVALID_S=1; AW*_S held stable.
  - AWREADY_M[owner] = AWREADY_S, combinational; the other bit is 0.
  - On AWVALID_S && AWREADY_S: drop AWVALID_S next cycle, clear beat counter, go to WDATA, toggle the pointer to the non-owner.
- WDATA:
  - WSEL = one-hot owner.
  - Each WVALID_S && WREADY_S increments the beat counter.
  - Burst ends on the handshake where WLAST_S=1 or counter==AWLEN_S, whichever comes first; then go to WRESP.
  - LEN_ERR pulses for one cycle on that ending handshake if WLAST_S and (counter==AWLEN_S) disagree.
- WRESP: BSEL = one-hot owner; on BVALID_S && BREADY_S go to IDLE and clear WSEL/BSEL.
- Outside WDATA, WSEL=0, so stray W beats are not routed.
- Outside WRESP, BSEL=0.
- No new AW grant until return to IDLE: one outstanding write at a time.
- A master dropping AWVALID_M after the grant does not cancel the registered request.
- Simultaneous requests resolve by the pointer; the pointer changes only on AW handshake.
- Counter width is LEN_BITS and never wraps, since the burst ends at counter==AWLEN_S.
- Reset mid-operation: immediate return to IDLE; the in-flight burst is abandoned and the pointer returns to M1.

Test Plan:
- Single M1 request, ADDR=0x0001_0000, LEN=3, ID=5: AWVALID_S high 1 cycle later; AWID_S=0x15; after 4 W beats with WLAST on beat 4, WSEL=01 then BSEL=01; LEN_ERR stays 0.
- M1 and M2 request in the same cycle, both held, 3 transactions: grant order M1, M2, M1; AWID_S tags 1, 2, 1.
- AWREADY_S held low 5 cycles in ADDR: AWVALID_S stays 1; AW*_S stable; AWREADY_M=00 throughout.
- LEN=3 but WLAST_S on beat 2: WDATA exits after beat 2; LEN_ERR pulses once. LEN=1 with WLAST never set: exits after beat 2; LEN_ERR pulses.
- M2 raises AWVALID during M1's WDATA: no grant until M1's B handshake; M2 gets AWVALID_S 1 cycle after IDLE is re-entered.
- rst asserted in WDATA mid-burst: AWVALID_S, WSEL, BSEL go 0 immediately; after release, a new M2 request is granted normally.
